serial_pattern_tx: RTL and testbench

Parallel-to-serial bit-pattern transmitter that drives a single-bit serial stream into the team's Moore sequence detectors (e.g. the non-overlapping 1100 detector). A producer loads a WIDTH-bit word through a valid/ready handshake. The block shifts the word out MSB-first, one bit per enabled clock, from a registered Moore FSM. Back-to-back loads yield a gap-free stream, so detector boundary cases can be driven from RTL instead of hand-timed testbench delays.

---
 rtl/serial_pattern_tx.sv | 85 ++++++++
 tb/tb_serial_pattern_tx.sv | 98 +++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: MSB-first parallel-to-serial transmitter with valid/ready load and gap-free back-to-back words.
// Define SERIAL_TX_PARITY_EN to append one even-parity bit after each word.
module serial_pattern_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             load_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif
    state_t state, state_next;
    logic [WIDTH-1:0] sreg, sreg_next;
    logic [CW-1:0] cnt, cnt_next;
    logic accept, last_data;
    assign last_data = state == SHIFT && cnt == CW'(1);
    assign out_valid = state != IDLE;
    assign load_ready = state == IDLE || done;
    assign accept = en && load_valid && load_ready;
`ifdef SERIAL_TX_PARITY_EN
    logic par, par_next;
    assign done = state == PARITY;
    assign out_bit = state == PARITY ? par : state == SHIFT && sreg[WIDTH-1];
`else
    assign done = last_data;
    assign out_bit = state == SHIFT && sreg[WIDTH-1];
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
`ifdef SERIAL_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            sreg  <= sreg_next;
            cnt   <= cnt_next;
`ifdef SERIAL_TX_PARITY_EN
            par   <= par_next;
`endif
        end
    end
    // An accept on the final-bit edge overrides the return to IDLE, giving gap-free words
    always_comb begin
        state_next = state;
        sreg_next  = sreg;
        cnt_next   = cnt;
`ifdef SERIAL_TX_PARITY_EN
        par_next   = par;
`endif
        if (accept) begin
            state_next = SHIFT;
            sreg_next  = data_in;
            cnt_next   = CW'(WIDTH);
`ifdef SERIAL_TX_PARITY_EN
            par_next   = ^data_in;
`endif
        end else if (en) begin
            if (state == SHIFT) begin
                sreg_next = sreg << 1;
                cnt_next  = cnt - CW'(1);
`ifdef SERIAL_TX_PARITY_EN
                if (last_data) state_next = PARITY;
`else
                if (last_data) state_next = IDLE;
`endif
            end
`ifdef SERIAL_TX_PARITY_EN
            else if (state == PARITY) state_next = IDLE;
`endif
        end
    end
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: scoreboard bench; the expected serial stream is built from accepted words as a bit queue.
module tb_serial_pattern_tx;
    localparam int W = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    typedef struct packed {logic b; logic last;} sbit_t;
    logic clk = 1'b0, rst = 1'b0, en = 1'b1, load_valid = 1'b0;
    logic [W-1:0] data_in = '0;
    logic load_ready, out_bit, out_valid, done;
    sbit_t q[$];
    int total = 0, bad = 0;
    serial_pattern_tx #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .load_valid(load_valid), .data_in(data_in),
        .load_ready(load_ready), .out_bit(out_bit), .out_valid(out_valid), .done(done)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got {valid,bit,done,ready}=%b expected %b", name, $time, act, exp);
        end
    endtask
    task automatic push_word(input logic [W-1:0] d);
        for (int i = W - 1; i >= 0; i--) q.push_back('{b: d[i], last: (i == 0) && !PAR});
        if (PAR) q.push_back('{b: ^d, last: 1'b1});
    endtask
    // called just after a rising edge; drives inputs for the next edge and records any accept
    task automatic step(input logic e, input logic lv, input logic [W-1:0] d);
        logic acc;
        en = e;
        load_valid = lv;
        data_in = d;
        acc = e && lv && rst && q.size() <= 1;
        @(posedge clk);
        if (acc) push_word(d);
        #1;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, W'($urandom()));
    endtask
    // monitor: compares what the DUT presents against the queue head, retiring the head when it is shifted out
    always @(negedge clk) begin
        if (rst) begin
            logic v, b, d;
            v = q.size() > 0;
            b = v ? q[0].b : 1'b0;
            d = v ? q[0].last : 1'b0;
            chk("stream", {out_valid, out_bit, done, load_ready}, {v, b, d, q.size() <= 1});
            if (en && v) void'(q.pop_front());
        end
    end
    initial begin
        en = 1'b1;
        load_valid = 1'b1;
        data_in = 4'b1100;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 chk("reset_hold", {out_valid, out_bit, done, load_ready}, 4'b0001);
        end
        rst = 1'b1;
        #1 chk("reset_release", {out_valid, out_bit, done, load_ready}, 4'b0001);
        step(1'b1, 1'b1, 4'b1100);
        idle(6);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'b1100);
        idle(6);
        step(1'b1, 1'b1, 4'b1010);
        step(1'b1, 1'b0, 4'b0000);
        step(1'b0, 1'b1, 4'b1111);
        step(1'b0, 1'b1, 4'b1111);
        idle(5);
        step(1'b1, 1'b1, 4'b0111);
        idle(2);
        #2 rst = 1'b0;
        #1 chk("async_reset", {out_valid, out_bit, done, load_ready}, 4'b0001);
        q.delete();
        @(posedge clk);
        #1 chk("reset_mid", {out_valid, out_bit, done, load_ready}, 4'b0001);
        rst = 1'b1;
        step(1'b1, 1'b1, 4'b1001);
        idle(6);
        step(1'b1, 1'b1, 4'b1101);
        idle(7);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, W'($urandom()));
        idle(8);
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending bits expected 0", q.size());
        end
        total++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
